game_screen_sequencer: RTL and testbench

Parametrised game-state sequencer and VGA source selector for the RPG top level. It tracks four game states: START, MAZE, BATTLE and END. It routes the matching screen generator's RGB/HS/VS to the monitor. Unlike a plain per-cycle mux, state changes are deferred to a frame boundary of the displayed source, and END returns to START automatically after a frame timeout.

---
 rtl/game_pkg.sv | 22 ++
 rtl/frame_edge_detect.sv | 26 ++
 rtl/game_screen_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_game_screen_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the RPG game-screen sequencer: state codes,
// source count and sync-level helpers.
package game_pkg;

    typedef enum logic [1:0] {
        ST_START  = 2'd0,
        ST_MAZE   = 2'd1,
        ST_BATTLE = 2'd2,
        ST_END    = 2'd3
    } game_state_t;

    localparam int NUM_SRC = 4;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    // Idle (inactive) level of a sync line for a given active polarity.
    function automatic logic sync_idle(input logic pol);
        return ~pol;
    endfunction

endpackage

// File: rtl/frame_edge_detect.sv
// Frame-start detector: one-cycle pulse in the cycle a VS line moves from
// its inactive to its active level, judged against a registered sample.
module frame_edge_detect
    import game_pkg::*;
#(
    parameter logic SYNC_POL = SYNC_ACTIVE_LOW
) (
    input  logic clk,
    input  logic rst,
    input  logic vs,
    output logic frame_start
);

    logic vs_prev;

    // Previous VS sample; starts idle so a reset never fakes a frame edge.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: registers are updated with non-blocking assignments so every
        // flop samples the pre-edge values, independent of statement order.
        if (!rst) vs_prev <= sync_idle(SYNC_POL);
        else      vs_prev <= vs;
    end

    assign frame_start = (vs == SYNC_POL) && (vs_prev != SYNC_POL);

endmodule

// File: rtl/game_screen_sequencer.sv
// Game-state sequencer and VGA source selector. Requests are captured into a
// pending target and committed on the next frame edge of the displayed
// source (or after SWITCH_TIMEOUT cycles). END returns to START after
// END_FRAMES frames. Optional macro GAME_SCREEN_BLANK_ON_SWITCH_EN blanks
// RGB after each commit until the new source's next frame edge.
module game_screen_sequencer
    import game_pkg::*;
#(
    parameter int   R_W            = 3,
    parameter int   G_W            = 3,
    parameter int   B_W            = 2,
    parameter logic SYNC_POL       = 1'b0,
    parameter int   END_FRAMES     = 180,
    parameter int   SWITCH_TIMEOUT = 1_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_req,
    input  logic                   enemy_collide,
    input  logic                   win_battle,
    input  logic                   lose_battle,
    input  logic                   win_game,
    input  logic                   restart_req,
    input  logic [NUM_SRC*R_W-1:0] r_in,
    input  logic [NUM_SRC*G_W-1:0] g_in,
    input  logic [NUM_SRC*B_W-1:0] b_in,
    input  logic [NUM_SRC-1:0]     hs_in,
    input  logic [NUM_SRC-1:0]     vs_in,
    output logic [R_W-1:0]         r,
    output logic [G_W-1:0]         g,
    output logic [B_W-1:0]         b,
    output logic                   hs,
    output logic                   vs,
    output logic [1:0]             state,
    output logic                   state_enter,
    output logic                   switch_pending
);

    localparam int TMO_W = (SWITCH_TIMEOUT > 1) ? $clog2(SWITCH_TIMEOUT) : 1;
    localparam int END_W = (END_FRAMES > 1) ? $clog2(END_FRAMES) : 1;
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(SWITCH_TIMEOUT - 1);
    localparam logic [END_W-1:0] END_MAX = END_W'(END_FRAMES - 1);

    game_state_t      state_q, state_d, target_q, target_d, req_target;
    logic             pending_q, pending_d;
    logic             req_valid, capture, commit, frame_edge;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [END_W-1:0] end_q, end_d;
    logic [1:0]       sel;
    logic             rgb_blank;

    frame_edge_detect #(.SYNC_POL(SYNC_POL)) u_frame_edge (
        .clk         (clk),
        .rst         (rst),
        .vs          (vs_in[state_q]),
        .frame_start (frame_edge)
    );

    // Decode which transition the current state is asking for this cycle.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        req_valid  = 1'b0;
        req_target = state_q;
        case (state_q)
            ST_START: if (start_req) begin
                req_valid  = 1'b1;
                req_target = ST_MAZE;
            end
            ST_MAZE: if (enemy_collide) begin
                req_valid  = 1'b1;
                req_target = ST_BATTLE;
            end
            ST_BATTLE: if (win_game || lose_battle) begin
                req_valid  = 1'b1;
                req_target = ST_END;
            end else if (win_battle) begin
                req_valid  = 1'b1;
                req_target = ST_MAZE;
            end
            ST_END: if (restart_req || (frame_edge && end_q == END_MAX)) begin
                req_valid  = 1'b1;
                req_target = ST_START;
            end
            default: ;
        endcase
    end

    // Next-state logic: capture a request, then commit on a frame edge or timeout.
    always_comb begin
        capture   = !pending_q && req_valid;
        commit    = pending_q && (frame_edge || tmo_q == TMO_MAX);
        state_d   = state_q;
        target_d  = target_q;
        pending_d = pending_q;
        tmo_d     = tmo_q;
        end_d     = end_q;

        if (commit) begin
            state_d   = target_q;
            pending_d = 1'b0;
            tmo_d     = '0;
            end_d     = '0;
        end else begin
            if (capture) begin
                target_d  = req_target;
                pending_d = 1'b1;
                tmo_d     = '0;
            end else if (pending_q && tmo_q != TMO_MAX) begin
                tmo_d = tmo_q + TMO_W'(1);
            end
            // The END frame count holds at its last value once the return fires.
            if (state_q == ST_END && !pending_q && frame_edge && end_q != END_MAX)
                end_d = end_q + END_W'(1);
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_START;
            target_q  <= ST_START;
            pending_q <= 1'b0;
            tmo_q     <= '0;
            end_q     <= '0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            pending_q <= pending_d;
            tmo_q     <= tmo_d;
            end_q     <= end_d;
        end
    end

`ifdef GAME_SCREEN_BLANK_ON_SWITCH_EN
    logic blank_q, blank_d;

    // Blanking arms on commit and disarms at the new source's first frame edge.
    always_comb begin
        blank_d = blank_q;
        if (commit)          blank_d = 1'b1;
        else if (frame_edge) blank_d = 1'b0;
    end

    // Blank flag register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) blank_q <= 1'b0;
        else      blank_q <= blank_d;
    end

    assign rgb_blank = blank_d;
`else
    assign rgb_blank = 1'b0;
`endif

    // The mux follows the next state so the commit cycle already shows the new source.
    assign sel = state_d;

    // Registered video output and commit pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r           <= '0;
            g           <= '0;
            b           <= '0;
            hs          <= sync_idle(SYNC_POL);
            vs          <= sync_idle(SYNC_POL);
            state_enter <= 1'b0;
        end else begin
            r           <= rgb_blank ? '0 : r_in[int'(sel)*R_W +: R_W];
            g           <= rgb_blank ? '0 : g_in[int'(sel)*G_W +: G_W];
            b           <= rgb_blank ? '0 : b_in[int'(sel)*B_W +: B_W];
            hs          <= hs_in[sel];
            vs          <= vs_in[sel];
            state_enter <= commit;
        end
    end

    assign state          = state_q;
    assign switch_pending = pending_q;

endmodule

// File: tb/tb_game_screen_sequencer.sv
// Scenario bench for game_screen_sequencer (END_FRAMES=3, SWITCH_TIMEOUT=16).
// Expected output words are queued when stimulus is driven and compared when
// the DUT has produced the corresponding registered output.
module tb_game_screen_sequencer;

`ifdef GAME_SCREEN_BLANK_ON_SWITCH_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif
    localparam logic [3:0] HS_PAT = 4'b0101;

    typedef struct packed {
        logic [1:0] st;
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
        logic       hs;
        logic       vs;
        logic       enter;
        logic       pend;
    } out_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_req, enemy_collide, win_battle, lose_battle, win_game, restart_req;
    logic [11:0] r_in, g_in;
    logic [7:0]  b_in;
    logic [3:0]  hs_in, vs_in;
    logic [2:0]  r, g;
    logic [1:0]  b;
    logic        hs, vs;
    logic [1:0]  state;
    logic        state_enter, switch_pending;

    out_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    game_screen_sequencer #(
        .R_W(3), .G_W(3), .B_W(2), .SYNC_POL(1'b0),
        .END_FRAMES(3), .SWITCH_TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .start_req(start_req), .enemy_collide(enemy_collide),
        .win_battle(win_battle), .lose_battle(lose_battle),
        .win_game(win_game), .restart_req(restart_req),
        .r_in(r_in), .g_in(g_in), .b_in(b_in), .hs_in(hs_in), .vs_in(vs_in),
        .r(r), .g(g), .b(b), .hs(hs), .vs(vs),
        .state(state), .state_enter(state_enter), .switch_pending(switch_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic out_t observe();
        out_t o;
        o.st = state; o.r = r; o.g = g; o.b = b;
        o.hs = hs; o.vs = vs; o.enter = state_enter; o.pend = switch_pending;
        return o;
    endfunction

    // Source s shows r=s+1, g=7-s, b=s, hs=HS_PAT[s].
    function automatic out_t exp_out(input logic [1:0] s, input logic vs_v,
                                     input logic enter, input logic pend, input logic blank);
        out_t       o;
        logic [3:0] hs_pat;
        hs_pat = HS_PAT;
        o.st = s;
        o.r  = {1'b0, s} + 3'd1;
        o.g  = 3'd7 - {1'b0, s};
        o.b  = s;
        if (BLANK_EN && blank) begin
            o.r = '0; o.g = '0; o.b = '0;
        end
        o.hs = hs_pat[s]; o.vs = vs_v; o.enter = enter; o.pend = pend;
        return o;
    endfunction

    function automatic out_t exp_reset();
        out_t o;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        return o;
    endfunction

    task automatic test_reset();
        out_t e, o;
        rst = 1'b1;
        #2 rst = 1'b0;
        sb_q.push_back(exp_reset());
        #1;
        e = sb_q.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL reset_initial: got=%h exp=%h", o, e); end
        step(); step();
        rst = 1'b1;
        sb_q.push_back(exp_out(2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        step();
        e = sb_q.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL reset_release: got=%h exp=%h", o, e); end
        step();
        #3 rst = 1'b0;
        sb_q.push_back(exp_reset());
        #1;
        e = sb_q.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL reset_async_mid: got=%h exp=%h", o, e); end
        sb_q.push_back(exp_reset());
        step();
        e = sb_q.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL reset_held: got=%h exp=%h", o, e); end
        rst = 1'b1;
        sb_q.push_back(exp_out(2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        step();
        e = sb_q.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL reset_src0_after_1clk: got=%h exp=%h", o, e); end
    endtask

    task automatic test_start();
        out_t e, o;
        start_req = 1'b1;
        sb_q.push_back(exp_out(2'd0, 1'b1, 1'b0, 1'b1, 1'b0));
        step();
        e = sb_q.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL start_capture: got=%h exp=%h", o, e); end
        start_req = 1'b0;
        sb_q.push_back(exp_out(2'd0, 1'b1, 1'b0, 1'b1, 1'b0));
        step();
        e = sb_q.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL start_wait_edge: got=%h exp=%h", o, e); end
        vs_in = 4'h0;
        sb_q.push_back(exp_out(2'd1, 1'b0, 1'b1, 1'b0, 1'b1));
        step();
        e = sb_q.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL start_commit_maze: got=%h exp=%h", o, e); end
        sb_q.push_back(exp_out(2'd1, 1'b0, 1'b0, 1'b0, 1'b1));
        step();
        e = sb_q.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL start_enter_one_cycle: got=%h exp=%h", o, e); end
        vs_in = 4'hF;
        sb_q.push_back(exp_out(2'd1, 1'b1, 1'b0, 1'b0, 1'b1));
        step();
        e = sb_q.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL start_sync_tracks: got=%h exp=%h", o, e); end
        vs_in = 4'h0;
        sb_q.push_back(exp_out(2'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        step();
        e = sb_q.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL start_colour_resume: got=%h exp=%h", o, e); end
        vs_in = 4'hF;
        step();
    endtask

    task automatic test_priority();
        out_t e, o;
        enemy_collide = 1'b1;
        sb_q.push_back(exp_out(2'd1, 1'b1, 1'b0, 1'b1, 1'b0));
        step();
        e = sb_q.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL prio_enemy_capture: got=%h exp=%h", o, e); end
        enemy_collide = 1'b0;
        vs_in = 4'h0;
        sb_q.push_back(exp_out(2'd2, 1'b0, 1'b1, 1'b0, 1'b1));
        step();
        e = sb_q.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL prio_commit_battle: got=%h exp=%h", o, e); end
        vs_in = 4'hF;
        step();
        win_battle = 1'b1; win_game = 1'b1;
        sb_q.push_back(exp_out(2'd2, 1'b1, 1'b0, 1'b1, 1'b1));
        step();
        e = sb_q.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL prio_both_capture: got=%h exp=%h", o, e); end
        win_battle = 1'b0; win_game = 1'b0;
        vs_in = 4'h0;
        sb_q.push_back(exp_out(2'd3, 1'b0, 1'b1, 1'b0, 1'b1));
        step();
        e = sb_q.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL prio_commit_end: got=%h exp=%h", o, e); end
        vs_in = 4'hF;
        step();
    endtask

    task automatic test_end_frames();
        out_t e, o;
        // Auto-return: request at frame 3, commit at frame 4.
        for (int f = 1; f <= 4; f++) begin
            vs_in = 4'h0;
            sb_q.push_back(exp_out((f < 4) ? 2'd3 : 2'd0, 1'b0, f == 4, f == 3, f == 4));
            step();
            e = sb_q.pop_front(); o = observe(); total++;
            if (o !== e) begin bad++; $display("FAIL end_auto_frame%0d: got=%h exp=%h", f, o, e); end
            vs_in = 4'hF;
            step(); step();
        end
        // Walk START -> MAZE -> BATTLE -> END again.
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       start_req     = 1'b1;
                1:       enemy_collide = 1'b1;
                default: lose_battle   = 1'b1;
            endcase
            step();
            start_req = 1'b0; enemy_collide = 1'b0; lose_battle = 1'b0;
            vs_in = 4'h0;
            sb_q.push_back(exp_out(2'(i + 1), 1'b0, 1'b1, 1'b0, 1'b1));
            step();
            e = sb_q.pop_front(); o = observe(); total++;
            if (o !== e) begin bad++; $display("FAIL end_walk%0d: got=%h exp=%h", i, o, e); end
            vs_in = 4'hF;
            step();
        end
        vs_in = 4'h0;
        sb_q.push_back(exp_out(2'd3, 1'b0, 1'b0, 1'b0, 1'b0));
        step();
        e = sb_q.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL end_restart_frame1: got=%h exp=%h", o, e); end
        vs_in = 4'hF;
        restart_req = 1'b1;
        sb_q.push_back(exp_out(2'd3, 1'b1, 1'b0, 1'b1, 1'b0));
        step();
        e = sb_q.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL end_restart_capture: got=%h exp=%h", o, e); end
        restart_req = 1'b0;
        step();
        vs_in = 4'h0;
        sb_q.push_back(exp_out(2'd0, 1'b0, 1'b1, 1'b0, 1'b1));
        step();
        e = sb_q.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL end_restart_commit: got=%h exp=%h", o, e); end
        vs_in = 4'hF;
        step();
    endtask

    task automatic test_timeout();
        out_t e, o;
        start_req = 1'b1;
        step();
        start_req = 1'b0;
        vs_in = 4'h0;
        sb_q.push_back(exp_out(2'd1, 1'b0, 1'b1, 1'b0, 1'b1));
        step();
        e = sb_q.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL tmo_enter_maze: got=%h exp=%h", o, e); end
        vs_in = 4'hF;
        step();
        // Inputs that belong to other states must be ignored in MAZE.
        start_req = 1'b1; win_battle = 1'b1; restart_req = 1'b1;
        sb_q.push_back(exp_out(2'd1, 1'b1, 1'b0, 1'b0, 1'b1));
        step();
        e = sb_q.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL tmo_unused_inputs: got=%h exp=%h", o, e); end
        start_req = 1'b0; win_battle = 1'b0; restart_req = 1'b0;
        enemy_collide = 1'b1;
        sb_q.push_back(exp_out(2'd1, 1'b1, 1'b0, 1'b1, 1'b1));
        step();
        e = sb_q.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL tmo_capture: got=%h exp=%h", o, e); end
        enemy_collide = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            sb_q.push_back(exp_out(2'd1, 1'b1, 1'b0, 1'b1, 1'b1));
            step();
            e = sb_q.pop_front(); o = observe(); total++;
            if (o !== e) begin bad++; $display("FAIL tmo_waiting_c%0d: got=%h exp=%h", k, o, e); end
        end
        sb_q.push_back(exp_out(2'd2, 1'b1, 1'b1, 1'b0, 1'b1));
        step();
        e = sb_q.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL tmo_forced_commit_c16: got=%h exp=%h", o, e); end
    endtask

    task automatic test_back_to_back();
        out_t e, o;
        win_battle = 1'b1;
        sb_q.push_back(exp_out(2'd2, 1'b1, 1'b0, 1'b1, 1'b1));
        step();
        e = sb_q.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL b2b_win_battle_capture: got=%h exp=%h", o, e); end
        vs_in = 4'h0;
        sb_q.push_back(exp_out(2'd1, 1'b0, 1'b1, 1'b0, 1'b1));
        step();
        e = sb_q.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL b2b_win_battle_commit: got=%h exp=%h", o, e); end
        vs_in = 4'hF;
        sb_q.push_back(exp_out(2'd1, 1'b1, 1'b0, 1'b0, 1'b1));
        step();
        e = sb_q.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL b2b_held_level_ignored: got=%h exp=%h", o, e); end
        win_battle = 1'b0;
        enemy_collide = 1'b1; vs_in = 4'h0;
        sb_q.push_back(exp_out(2'd1, 1'b0, 1'b0, 1'b1, 1'b0));
        step();
        e = sb_q.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL b2b_capture_on_edge: got=%h exp=%h", o, e); end
        enemy_collide = 1'b0; vs_in = 4'hF;
        sb_q.push_back(exp_out(2'd1, 1'b1, 1'b0, 1'b1, 1'b0));
        step();
        e = sb_q.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL b2b_no_same_edge_commit: got=%h exp=%h", o, e); end
        vs_in = 4'h0;
        sb_q.push_back(exp_out(2'd2, 1'b0, 1'b1, 1'b0, 1'b1));
        step();
        e = sb_q.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL b2b_next_edge_commit: got=%h exp=%h", o, e); end
        vs_in = 4'hF;
        step();
    endtask

    initial begin
        start_req = 1'b0; enemy_collide = 1'b0; win_battle = 1'b0;
        lose_battle = 1'b0; win_game = 1'b0; restart_req = 1'b0;
        r_in  = {3'd4, 3'd3, 3'd2, 3'd1};
        g_in  = {3'd4, 3'd5, 3'd6, 3'd7};
        b_in  = {2'd3, 2'd2, 2'd1, 2'd0};
        hs_in = HS_PAT;
        vs_in = 4'hF;
        test_reset();
        test_start();
        test_priority();
        test_end_frames();
        test_timeout();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
